// File: rtl/dvga_timebase_if.sv
// Control and status bundle between the dvga timebase and its controller.
// The master drives run/resync/divisor writes; the slave returns reset and enables.
interface dvga_timebase_if #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned DIVW = 8
);
  logic            en_i;
  logic            sync_i;
  logic [NCH-1:0]  div_we;
  logic [DIVW-1:0] div_data;
  logic            rst_o;
  logic [NCH-1:0]  ce_o;
  logic [NCH-1:0]  pend_o;

  modport master (
    output en_i,
    output sync_i,
    output div_we,
    output div_data,
    input  rst_o,
    input  ce_o,
    input  pend_o
  );

  modport slave (
    input  en_i,
    input  sync_i,
    input  div_we,
    input  div_data,
    output rst_o,
    output ce_o,
    output pend_o
  );
endinterface

// File: rtl/dvga_timebase.sv
// Reset stretcher plus NCH programmable clock-enable dividers for the dvga subsystem.
// Divisor writes made while running are deferred to the next wrap so periods never glitch.
module dvga_timebase #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned DIVW        = 8,
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  dvga_timebase_if.slave        bus_io
);

  localparam int unsigned HW = $clog2(RST_HOLD + 1);

  logic [HW-1:0]   hold_q, hold_d;
  logic            rst_o_q, rst_o_d;
  logic [NCH-1:0]  ce_q, ce_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  wrap;
  logic            run;

  logic [DIVW-1:0] cnt_q      [NCH];
  logic [DIVW-1:0] cnt_d      [NCH];
  logic [DIVW-1:0] div_q      [NCH];
  logic [DIVW-1:0] div_d      [NCH];
  logic [DIVW-1:0] div_pend_q [NCH];
  logic [DIVW-1:0] div_pend_d [NCH];

  assign run = !rst_o_q && bus_io.en_i && !bus_io.sync_i;

  // Reset hold-off: rst_o drops on the edge that takes the count from 1 to 0.
  always_comb begin
    hold_d  = hold_q;
    rst_o_d = rst_o_q;
    if (hold_q != '0) begin
      hold_d  = hold_q - HW'(1);
      rst_o_d = (hold_q > HW'(1));
    end
  end

  // Treating cnt > div as a wrap keeps a shrunken divisor from locking the counter.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i] = (cnt_q[i] >= div_q[i]);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    ce_d       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus_io.sync_i) begin
        cnt_d[i] = '0;
        if (bus_io.div_we[i]) begin
          div_d[i] = bus_io.div_data;
        end else if (pend_q[i]) begin
          div_d[i] = div_pend_q[i];
        end
        pend_d[i] = 1'b0;
      end else if (run) begin
        if (wrap[i]) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
          if (pend_q[i]) begin
            div_d[i]  = div_pend_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIVW'(1);
        end
        // A write on a wrap edge only arms the next wrap.
        if (bus_io.div_we[i]) begin
          div_pend_d[i] = bus_io.div_data;
          pend_d[i]     = 1'b1;
        end
      end else if (bus_io.div_we[i]) begin
        div_d[i]  = bus_io.div_data;
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= HW'(RST_HOLD);
      rst_o_q <= 1'b1;
      ce_q    <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        div_q[i]      <= DIVW'(DEFAULT_DIV);
        div_pend_q[i] <= '0;
      end
    end else begin
      hold_q  <= hold_d;
      rst_o_q <= rst_o_d;
      ce_q    <= ce_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_q[i]      <= div_d[i];
        div_pend_q[i] <= div_pend_d[i];
      end
    end
  end

  assign bus_io.rst_o  = rst_o_q;
  assign bus_io.ce_o   = ce_q;
  assign bus_io.pend_o = pend_q;

endmodule

// File: tb/tb_dvga_timebase.sv
// Directed bench for dvga_timebase: a per-cycle vector table for reset stretch and
// divisor behaviour, then hand-written pause/resync and mid-run reset sequences.
module tb_dvga_timebase;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dvga_timebase_if #(.NCH(2), .DIVW(8)) bus_if ();

  dvga_timebase #(
    .NCH(2),
    .DIVW(8),
    .RST_HOLD(4),
    .DEFAULT_DIV(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus_if)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       sync;
    logic [1:0] we;
    logic [7:0] data;
    logic       e_rst;
    logic [1:0] e_ce;
    logic [1:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic r, input logic en, input logic sy,
                              input logic [1:0] we, input logic [7:0] data, input logic er,
                              input logic [1:0] ece, input logic [1:0] epend);
    vec_t v;
    v.rst = r; v.en = en; v.sync = sy; v.we = we; v.data = data;
    v.e_rst = er; v.e_ce = ece; v.e_pend = epend;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic en, input logic sy, input logic [1:0] we,
                      input logic [7:0] data);
    @(negedge clk);
    rst             = r;
    bus_if.en_i     = en;
    bus_if.sync_i   = sy;
    bus_if.div_we   = we;
    bus_if.div_data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.en_i     = 1'b0;
    bus_if.sync_i   = 1'b0;
    bus_if.div_we   = '0;
    bus_if.div_data = '0;

    // Reset stretch; divisors written directly during hold-off (div0=0, div1=2).
    add(5, 1, 0, 0, 2'b00, 8'd0, 1, 2'b00, 2'b00);
    add(1, 0, 0, 0, 2'b01, 8'd0, 1, 2'b00, 2'b00);
    add(1, 0, 0, 0, 2'b10, 8'd2, 1, 2'b00, 2'b00);
    add(1, 0, 0, 0, 2'b00, 8'd0, 1, 2'b00, 2'b00);
    add(1, 0, 0, 0, 2'b00, 8'd0, 0, 2'b00, 2'b00);
    add(1, 0, 0, 0, 2'b00, 8'd0, 0, 2'b00, 2'b00);
    // Divide ratios: ch1 pulses on running edges 3, 6, 9.
    for (int p = 0; p < 3; p++) begin
      add(2, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b00);
      add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    end
    // Write div1=4 one cycle after a pulse: old period completes, then period 5.
    add(1, 0, 1, 0, 2'b10, 8'd4, 0, 2'b01, 2'b10);
    add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b10);
    add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    add(4, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b00);
    add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    // Back to div1=2, then write div1=1 on a wrap edge.
    add(1, 0, 1, 0, 2'b10, 8'd2, 0, 2'b01, 2'b10);
    add(3, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b10);
    add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    add(2, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b00);
    add(1, 0, 1, 0, 2'b10, 8'd1, 0, 2'b11, 2'b10);
    add(2, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b10);
    add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    for (int p = 0; p < 2; p++) begin
      add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b01, 2'b00);
      add(1, 0, 1, 0, 2'b00, 8'd0, 0, 2'b11, 2'b00);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sync, vecs[i].we, vecs[i].data);
      chk($sformatf("vec%0d.rst_o", i), {7'd0, bus_if.rst_o}, {7'd0, vecs[i].e_rst});
      chk($sformatf("vec%0d.ce_o", i), {6'd0, bus_if.ce_o}, {6'd0, vecs[i].e_ce});
      chk($sformatf("vec%0d.pend_o", i), {6'd0, bus_if.pend_o}, {6'd0, vecs[i].e_pend});
    end

    // Pause: div1=3 written while paused goes straight in.
    step(0, 0, 0, 2'b10, 8'd3);
    chk("pause_wr.ce", {6'd0, bus_if.ce_o}, 8'h00);
    chk("pause_wr.pend", {6'd0, bus_if.pend_o}, 8'h00);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 2'b00, 8'd0);
      chk($sformatf("pre_pause%0d.ce", k), {6'd0, bus_if.ce_o}, 8'h01);
    end
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 2'b00, 8'd0);
      chk($sformatf("paused%0d.ce", k), {6'd0, bus_if.ce_o}, 8'h00);
    end
    step(0, 1, 0, 2'b00, 8'd0);
    chk("resume0.ce", {6'd0, bus_if.ce_o}, 8'h01);
    step(0, 1, 0, 2'b00, 8'd0);
    chk("resume1.ce", {6'd0, bus_if.ce_o}, 8'h03);

    // Pending write then sync: pending value applied, pend cleared, phase restarts.
    step(0, 1, 0, 2'b10, 8'd3);
    chk("pre_sync.pend", {6'd0, bus_if.pend_o}, 8'h02);
    step(0, 1, 1, 2'b00, 8'd0);
    chk("sync.ce", {6'd0, bus_if.ce_o}, 8'h00);
    chk("sync.pend", {6'd0, bus_if.pend_o}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 2'b00, 8'd0);
      chk($sformatf("post_sync%0d.ce", k), {6'd0, bus_if.ce_o}, (k == 3) ? 8'h03 : 8'h01);
    end

    // Reset mid-operation with ch0 write pending.
    step(0, 1, 0, 2'b01, 8'd5);
    chk("mid.pend", {6'd0, bus_if.pend_o}, 8'h01);
    chk("mid.ce", {6'd0, bus_if.ce_o}, 8'h01);
    step(1, 1, 0, 2'b00, 8'd0);
    chk("mid_rst.rst_o", {7'd0, bus_if.rst_o}, 8'h01);
    chk("mid_rst.ce", {6'd0, bus_if.ce_o}, 8'h00);
    chk("mid_rst.pend", {6'd0, bus_if.pend_o}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 2'b00, 8'd0);
      chk($sformatf("rehold%0d.rst_o", k), {7'd0, bus_if.rst_o}, (k == 3) ? 8'h00 : 8'h01);
      chk($sformatf("rehold%0d.ce", k), {6'd0, bus_if.ce_o}, 8'h00);
    end
    // Default divisor 0 on both channels: enable every running cycle.
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 2'b00, 8'd0);
      chk($sformatf("default%0d.ce", k), {6'd0, bus_if.ce_o}, 8'h03);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvga_timebase.md
Name: dvga_timebase

Overview:
- Parametrised, synthesizable timebase for the dvga subsystem. It generates the dvga reset and clock enables from the single system clock.
- Stretches the incoming synchronous reset into a held reset output (rst_o).
- Produces NCH independent clock-enable pulse trains (pixel, character and blink enables) with run-time programmable divisors.
- Divisor changes are glitch-free; all phases can be resynchronised together.

Parameters:
- NCH, 2, number of clock-enable channels (1..8).
- DIVW, 8, width of each divisor and phase counter.
- RST_HOLD, 4, rst_o hold-off in cycles after rst is sampled low (must be >= 1).
- DEFAULT_DIV, 0, divisor loaded into every channel on reset (period = divisor+1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- en_i  in  1  global run enable; 0 pauses all channels.
- sync_i  in  1  phase resync; clears all channel counters.
- div_we  in  NCH  per-channel divisor write strobe.
- div_data  in  DIVW  divisor value for the write.
- rst_o  out  1  stretched reset to dvga logic, registered.
- ce_o  out  NCH  one-cycle clock-enable pulses, registered.
- pend_o  out  NCH  a divisor write is pending for that channel.

Behaviour:
- Reset (rst=1 at an edge):
  - hold_cnt<=RST_HOLD, rst_o<=1.
  - For every channel: cnt<=0, div<=DEFAULT_DIV, pend<=0, ce_o<=0.
  - rst overrides every other input.
- Hold-off, on each edge with rst=0:
  - If hold_cnt!=0: hold_cnt<=hold_cnt-1 and rst_o<=(hold_cnt>1).
  - Result: rst_o falls after exactly RST_HOLD edges with rst low.
  - A rst pulse during hold-off reloads the count to RST_HOLD.
- Running edge definition: rst=0, rst_o=0, en_i=1, sync_i=0.
- Channel i on a running edge:
  - If cnt==div: cnt<=0, ce_o[i]<=1 (wrap). If pend: div<=div_pend, pend<=0.
  - Else: cnt<=cnt+1, ce_o[i]<=0.
  - Result: a pulse every div+1 cycles; div=0 gives ce_o high every running cycle.
  - The first pulse appears div+1 running edges after the counters start from 0.
- Paused edge (rst_o=1 or en_i=0, and sync_i=0): ce_o<=0 and cnt is held, so the phase is kept across pauses.
- sync_i=1 (rst=0): all cnt<=0, ce_o<=0. Every pending divisor is applied immediately and pend is cleared.
- Divisor writes, div_we[i] at an edge with rst=0:
  - Running, no sync: div_pend<=div_data, pend<=1. The new value is applied at the first wrap strictly after the write edge. A write on the same edge as a wrap is not applied on that wrap; that wrap uses the old divisor.
  - Paused (rst_o=1 or en_i=0) or sync_i=1: div<=div_data directly, pend<=0.
  - A second write while pending overwrites div_pend (last write wins).
- Counter arithmetic is unsigned DIVW bits. If cnt>div is ever observed, the next running edge treats it as a wrap (cnt<=0, ce pulse); it cannot lock up.
- pend_o = registered pend bits.
- Reset values of outputs: rst_o=1, ce_o=0, pend_o=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset stretch: assert rst 5 cycles, deassert. Required: rst_o=1 for exactly 4 further edges with rst low, then 0; ce_o=0 throughout.
- Divide ratios (NCH=2): div0=0, div1=2, en_i=1 after rst_o falls. Required: ce_o[0] high every cycle from the first running edge; ce_o[1] pulses on the 3rd, 6th, 9th running edges.
- Glitch-free change: ch1 div=2 running; write div=4 one cycle after a pulse. Required: pend_o[1]=1; next pulse still 3 cycles after the previous one; then pulses every 5 cycles; pend_o[1] clears on that wrap.
- Write coincident with wrap: write div=1 on the ch1 wrap edge. Required: the following period is still 3 cycles, then 2-cycle periods.
- Pause/resync: ch1 div=3, drop en_i 10 cycles mid-period. Required: no pulses while paused and the phase resumes unchanged. Then pulse sync_i. Required: counters cleared; next ch1 pulse exactly 4 running edges later.
- Reset mid-operation: assert rst while pend_o=01 and pulses are active. Required: next edge ce_o=0, pend_o=0, div=DEFAULT_DIV, rst_o=1, hold-off restarts at 4.
